// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single synchronous-read data-memory port between the multicycle
// core (requester 0, read/write) and the display/keyboard refresh reader
// (requester 1, read-only). One requester is granted per cycle. Read data comes
// back one cycle after the grant and is tagged to the requester that issued it.
//
// The core normally has priority. While both requesters contend, the display
// is allowed to lose STARVE_LIMIT times. After that it takes priority for a
// burst of up to BURST_LEN consecutive grants, and then priority returns to
// the core.
//
// Ports
//   clk, reset                 system clock, synchronous active-high reset
//   cpu_req/we/addr/wdata      core request
//   cpu_gnt                    core owns the port this cycle (combinational)
//   cpu_rvalid/rdata           core read return, one cycle after a read grant
//   disp_req/addr              display read request
//   disp_gnt                   display owns the port this cycle (combinational)
//   disp_rvalid/rdata          display read return, one cycle after the grant
//   mem_addr/we/wdata          muxed memory request
//   mem_rdata                  memory read data, valid the cycle after address
//   conflict_cnt               saturating count of cycles with both requests
//
// state        | meaning
// -------------+-------------------------------------------------------------
// S_CPU_PRI    | core has priority; wait_cnt counts display losses under
//              | contention
// S_DISP_BURST | display has priority; burst_cnt counts display grants in
//              | the current burst
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int BURST_LEN    = 2,
    parameter int CW           = 16
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,

    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_gnt,
    output logic          disp_rvalid,
    output logic [DW-1:0] disp_rdata,

    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic [CW-1:0] conflict_cnt
);

    localparam int WW = $clog2(STARVE_LIMIT + 1);
    localparam int BW = $clog2(BURST_LEN + 1);

    localparam logic [WW-1:0] WAIT_MAX  = WW'(STARVE_LIMIT);
    localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN);

    typedef enum logic {
        S_CPU_PRI    = 1'b0,
        S_DISP_BURST = 1'b1
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_n;
    logic [WW-1:0] wait_eff;
    logic [BW-1:0] burst_cnt;
    logic [BW-1:0] burst_n;
    logic          gnt_c;
    logic          gnt_d;
    logic          cpu_rvalid_q;
    logic          disp_rvalid_q;
    logic          both_req;

    assign both_req = cpu_req & disp_req;

    // Arbitration decision and next-state values. Only request inputs and
    // arbiter state feed the grants; memory read data never does.
    always_comb begin
        gnt_c    = 1'b0;
        gnt_d    = 1'b0;
        state_n  = state;
        wait_n   = wait_cnt;
        burst_n  = burst_cnt;
        wait_eff = wait_cnt;

        if (state == S_DISP_BURST && disp_req && burst_cnt < BURST_MAX) begin
            gnt_d   = 1'b1;
            burst_n = burst_cnt + BW'(1);
        end else begin
            // Leaving a burst hands priority straight back to the core in the
            // same cycle, as if the display had not been waiting at all.
            if (state == S_DISP_BURST) begin
                wait_eff = '0;
            end
            state_n = S_CPU_PRI;
            burst_n = '0;
            if (both_req) begin
                if (wait_eff >= WAIT_MAX) begin
                    gnt_d   = 1'b1;
                    burst_n = BW'(1);
                    wait_n  = '0;
                    state_n = S_DISP_BURST;
                end else begin
                    gnt_c  = 1'b1;
                    // wait_eff < WAIT_MAX here, so the increment saturates at
                    // WAIT_MAX without an explicit clamp.
                    wait_n = wait_eff + WW'(1);
                end
            end else begin
                gnt_c  = cpu_req;
                gnt_d  = disp_req;
                wait_n = '0;
            end
        end
    end

    assign cpu_gnt  = gnt_c & ~reset;
    assign disp_gnt = gnt_d & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_CPU_PRI;
            wait_cnt      <= '0;
            burst_cnt     <= '0;
            cpu_rvalid_q  <= 1'b0;
            disp_rvalid_q <= 1'b0;
            conflict_cnt  <= '0;
        end else begin
            state         <= state_n;
            wait_cnt      <= wait_n;
            burst_cnt     <= burst_n;
            cpu_rvalid_q  <= gnt_c & ~cpu_we;
            disp_rvalid_q <= gnt_d;
            if (both_req && conflict_cnt != {CW{1'b1}}) begin
                conflict_cnt <= conflict_cnt + CW'(1);
            end
        end
    end

    // A read granted in the last cycle before reset would otherwise show its
    // rvalid during the reset cycle; reset suppresses it.
    assign cpu_rvalid  = cpu_rvalid_q & ~reset;
    assign disp_rvalid = disp_rvalid_q & ~reset;

    assign cpu_rdata  = cpu_rvalid  ? mem_rdata : '0;
    assign disp_rdata = disp_rvalid ? mem_rdata : '0;

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end else if (disp_gnt) begin
            mem_addr = disp_addr;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int SL = 4;
    localparam int BL = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, disp_req;
    logic [31:0] cpu_addr, cpu_wdata, disp_addr;
    logic [31:0] mem_rdata;

    logic        cpu_gnt, cpu_rvalid, disp_gnt, disp_rvalid, mem_we;
    logic [31:0] cpu_rdata, disp_rdata, mem_addr, mem_wdata;
    logic [15:0] conflict_cnt;

    logic        s_cpu_gnt, s_cpu_rvalid, s_disp_gnt, s_disp_rvalid, s_mem_we;
    logic [31:0] s_cpu_rdata, s_disp_rdata, s_mem_addr, s_mem_wdata;
    logic [3:0]  s_conflict_cnt;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .conflict_cnt(conflict_cnt)
    );

    mem_port_arbiter #(.CW(4)) dut_small (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(s_cpu_gnt), .cpu_rvalid(s_cpu_rvalid), .cpu_rdata(s_cpu_rdata),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(s_disp_gnt),
        .disp_rvalid(s_disp_rvalid), .disp_rdata(s_disp_rdata),
        .mem_addr(s_mem_addr), .mem_we(s_mem_we), .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata),
        .conflict_cnt(s_conflict_cnt)
    );

    // Memory block: synchronous read, 256 words indexed by addr[9:2].
    function automatic logic [31:0] init_val(input int i);
        if (i == 'h60) return 32'hDEADBEEF;
        return {8'(i), 8'(~i), 8'(i ^ 'h5A), 8'h3C};
    endfunction

    bit [31:0] tb_mem  [256];
    bit        written [256];

    always @(posedge clk) begin : mem_blk
        int k;
        k = int'(mem_addr[9:2]);
        if (mem_we) begin
            tb_mem[k]  <= mem_wdata;
            written[k] <= 1'b1;
        end
        mem_rdata <= written[k] ? tb_mem[k] : init_val(k);
    end

    // Reference model state
    int          checks = 0;
    int          errors = 0;
    int          m_wait;
    int          m_burst;     // >0 while the display holds priority
    int          m_conf;
    logic        m_pc, m_pd;
    logic [31:0] m_pcd, m_pdd;
    logic [31:0] m_mem [256];
    logic        last_cg, last_dg;
    logic        obs_cg, obs_dg, obs_we, obs_crv;
    logic [31:0] obs_wd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // One clock cycle: drive inputs just after the falling edge, check every
    // output against the model 2 time units later, then advance the model.
    task automatic step(input logic rst, input logic c_req, input logic c_we,
                        input logic [31:0] c_addr, input logic [31:0] c_wd,
                        input logic d_req, input logic [31:0] d_addr);
        logic        e_cg, e_dg, e_we;
        logic [31:0] e_addr, e_wd;
        int          w, n_wait, n_burst;
        reset = rst; cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr;
        cpu_wdata = c_wd; disp_req = d_req; disp_addr = d_addr;
        #2;
        e_cg = 1'b0; e_dg = 1'b0;
        n_wait = m_wait; n_burst = m_burst;
        if (m_burst > 0 && d_req && m_burst < BL) begin
            e_dg = 1'b1;
            n_burst = m_burst + 1;
        end else begin
            w = (m_burst > 0) ? 0 : m_wait;
            n_burst = 0;
            if (c_req && d_req) begin
                if (w >= SL) begin
                    e_dg = 1'b1; n_burst = 1; n_wait = 0;
                end else begin
                    e_cg = 1'b1; n_wait = sat(w + 1, SL);
                end
            end else begin
                e_cg = c_req; e_dg = d_req; n_wait = 0;
            end
        end
        if (rst) begin
            e_cg = 1'b0; e_dg = 1'b0;
        end
        e_addr = e_cg ? c_addr : (e_dg ? d_addr : 32'h0);
        e_we   = e_cg & c_we;
        e_wd   = e_cg ? c_wd : 32'h0;

        chk("cpu_gnt", cpu_gnt, e_cg);
        chk("disp_gnt", disp_gnt, e_dg);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_we", mem_we, e_we);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("cpu_rvalid", cpu_rvalid, m_pc & ~rst);
        chk("disp_rvalid", disp_rvalid, m_pd & ~rst);
        if (m_pc && !rst) chk("cpu_rdata", cpu_rdata, m_pcd);
        if (m_pd && !rst) chk("disp_rdata", disp_rdata, m_pdd);
        chk("conflict_cnt", conflict_cnt, sat(m_conf, 65535));
        chk("s_cpu_gnt", s_cpu_gnt, e_cg);
        chk("s_disp_gnt", s_disp_gnt, e_dg);
        chk("s_mem_addr", s_mem_addr, e_addr);
        chk("s_mem_we", s_mem_we, e_we);
        chk("s_mem_wdata", s_mem_wdata, e_wd);
        chk("s_cpu_rvalid", s_cpu_rvalid, m_pc & ~rst);
        chk("s_disp_rvalid", s_disp_rvalid, m_pd & ~rst);
        if (m_pc && !rst) chk("s_cpu_rdata", s_cpu_rdata, m_pcd);
        if (m_pd && !rst) chk("s_disp_rdata", s_disp_rdata, m_pdd);
        chk("s_conflict_cnt", s_conflict_cnt, sat(m_conf, 15));

        obs_cg = cpu_gnt; obs_dg = disp_gnt; obs_we = mem_we;
        obs_wd = mem_wdata; obs_crv = cpu_rvalid;

        if (rst) begin
            m_wait = 0; m_burst = 0; m_conf = 0; m_pc = 1'b0; m_pd = 1'b0;
        end else begin
            m_wait = n_wait; m_burst = n_burst;
            if (c_req && d_req) m_conf = m_conf + 1;
            m_pc  = e_cg & ~c_we;
            m_pcd = m_mem[c_addr[9:2]];
            m_pd  = e_dg;
            m_pdd = m_mem[d_addr[9:2]];
            if (e_cg && c_we) m_mem[c_addr[9:2]] = c_wd;
        end
        last_cg = e_cg; last_dg = e_dg;
        @(negedge clk);
    endtask

    initial begin
        logic        cr, cw, dr, rs;
        logic [31:0] ca, cd, da;
        for (int i = 0; i < 256; i++) m_mem[i] = init_val(i);
        m_wait = 0; m_burst = 0; m_conf = 0; m_pc = 1'b0; m_pd = 1'b0;
        last_cg = 1'b0; last_dg = 1'b0;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
        cpu_wdata = '0; disp_req = 1'b0; disp_addr = '0;
        @(negedge clk);

        // Reset, then idle
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 32'h44, 32'h99, 1, 32'h88);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Core read of 0x2580
        step(0, 1, 0, 32'h2580, 0, 0, 0);
        chk("rd_gnt", obs_cg, 1'b1);
        chk("rd_rvalid", cpu_rvalid, 1'b1);
        chk("rd_rdata", cpu_rdata, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0, 0);

        // Core write 0x55 to 0x10, then read it back
        step(0, 1, 1, 32'h10, 32'h55, 0, 0);
        chk("wr_we", obs_we, 1'b1);
        chk("wr_wdata", obs_wd, 32'h55);
        chk("wr_no_rvalid", cpu_rvalid, 1'b0);
        step(0, 1, 0, 32'h10, 0, 0, 0);
        chk("rb_rdata", cpu_rdata, 32'h55);

        // Read granted, reset in the following cycle
        step(0, 1, 0, 32'h40, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_mid_rvalid", obs_crv, 1'b0);
        chk("rst_after_rvalid", cpu_rvalid, 1'b0);

        // Continuous contention
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 32'h100, 0, 1, 32'h200);
            chk("pat_cpu", obs_cg, (i % 6) < 4);
            chk("pat_disp", obs_dg, (i % 6) >= 4);
            if (i == 11) begin
                chk("conf12", conflict_cnt, 12);
                chk("s_conf12", s_conflict_cnt, 12);
            end
        end
        chk("conf20", conflict_cnt, 20);
        chk("s_conf_sat", s_conflict_cnt, 15);

        // Display-only stream
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, 0, 1, 32'h300 + 32'(i * 4));
            chk("disp_only", obs_dg, 1'b1);
        end

        // Enter burst, continue with display only, core returns and cuts it off
        for (int i = 0; i < 5; i++) step(0, 1, 0, 32'h104, 0, 1, 32'h204);
        chk("burst_enter", obs_dg, 1'b1);
        step(0, 0, 0, 0, 0, 1, 32'h208);
        chk("burst_second", obs_dg, 1'b1);
        step(0, 1, 0, 32'h104, 0, 1, 32'h20C);
        chk("burst_cut", obs_cg, 1'b1);

        // Enter burst again, display drops after one grant
        for (int i = 0; i < 4; i++) step(0, 1, 0, 32'h108, 0, 1, 32'h210);
        chk("burst2_enter", obs_dg, 1'b1);
        step(0, 1, 0, 32'h108, 0, 0, 0);
        chk("drop_cpu", obs_cg, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 32'h10C, 0, 1, 32'h214);
            chk("drop_wait0", obs_dg, i == 4);
        end

        // Randomized traffic under the requester contract
        cr = 1'b0; cw = 1'b0; ca = '0; cd = '0; dr = 1'b0; da = '0;
        for (int n = 0; n < 600; n++) begin
            if (cr && !last_cg) begin
                if ($urandom_range(0, 7) == 0) cr = 1'b0;
            end else begin
                cr = ($urandom_range(0, 3) != 0);
                cw = 1'($urandom_range(0, 1));
                ca = 32'($urandom_range(0, 63)) << 2;
                cd = $urandom;
            end
            if (dr && !last_dg) begin
                if ($urandom_range(0, 7) == 0) dr = 1'b0;
            end else begin
                dr = ($urandom_range(0, 2) != 0);
                da = 32'($urandom_range(0, 63)) << 2;
            end
            rs = ($urandom_range(0, 99) == 0);
            step(rs, cr, cw, ca, cd, dr, da);
            if (rs) begin
                cr = 1'b0; dr = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
